// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, sequencer state type and opcode check shared by the bit-serial ALU
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bit_serial_alu_if.sv
// rtl/bit_serial_alu_if.sv - request/response bundle between the EX stage and the bit-serial ALU
interface bit_serial_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             illegal_op;

    modport master (
        output in_valid, op, src_a, src_b,
        input  in_ready, done, result, carry_out, overflow, zero, illegal_op
    );

    modport slave (
        input  in_valid, op, src_a, src_b,
        output in_ready, done, result, carry_out, overflow, zero, illegal_op
    );

endinterface

// File: rtl/one_bit_alu.sv
// rtl/one_bit_alu.sv - single ALU slice; with sub set the adder becomes a b - a - borrow_in subtractor
module one_bit_alu
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       less,
    input  logic       sub,
    input  logic [3:0] op,
    output logic       r,
    output logic       cout,
    output logic       set
);

    logic sum;

    always_comb begin
        sum  = a ^ b ^ cin;
        // In subtract mode cin/cout carry a borrow rather than a carry
        cout = sub ? ((a & ~b) | (~(a ^ b) & cin))
                   : ((a & b) | (cin & (a ^ b)));
        set  = sum;
        case (op)
            OP_AND:         r = a & b;
            OP_OR:          r = a | b;
            OP_ADD, OP_SUB: r = sum;
            OP_SLT:         r = less;
            OP_NOR:         r = ~(a | b);
            default:        r = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// rtl/bit_serial_alu.sv - LSB-first WIDTH-cycle ALU sequencer around one one_bit_alu slice
// Optional build macro SLT_OVF_FIX_EN: SLT uses sign XOR overflow instead of the raw sign.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    bit_serial_alu_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;

    logic             is_arith, is_sub, last_bit;
    logic             s_a, s_b, s_r, s_cout, s_set;
    logic             ovf_w, less_bit;
    logic [WIDTH-1:0] res_full;

    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    assign is_sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // The slice subtracts a from b, so operands are swapped to get A - B
    assign s_a = is_sub ? b_sh_q[0] : a_sh_q[0];
    assign s_b = is_sub ? a_sh_q[0] : b_sh_q[0];

    one_bit_alu u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .less (1'b0),
        .sub  (is_sub),
        .op   (op_q),
        .r    (s_r),
        .cout (s_cout),
        .set  (s_set)
    );

    assign ovf_w    = carry_q ^ s_cout;
    assign res_full = {s_r, res_sh_q};
`ifdef SLT_OVF_FIX_EN
    assign less_bit = s_set ^ ovf_w;
`else
    assign less_bit = s_set;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = is_legal_op(bus.op) ? SHIFT : FIN;
            SHIFT:   if (last_bit) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == IDLE);
        bus.done     = (state_q == FIN);
    end

    always_comb begin
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_sh_d  = res_sh_q;
        carry_d   = carry_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_d      = bus.op;
                    a_sh_d    = bus.src_a;
                    b_sh_d    = bus.src_b;
                    carry_d   = 1'b0;
                    cnt_d     = '0;
                    illegal_d = !is_legal_op(bus.op);
                    if (!is_legal_op(bus.op)) begin
                        result_d = '0;
                        cout_d   = 1'b0;
                        ovf_d    = 1'b0;
                        zero_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_full[WIDTH-1:1];
                carry_d  = is_arith ? s_cout : 1'b0;
                cnt_d    = cnt_q + CW'(1);
                // Final flags are taken straight from the MSB slice so they land with FIN
                if (last_bit) begin
                    result_d = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, less_bit} : res_full;
                    cout_d   = is_arith ? s_cout : 1'b0;
                    ovf_d    = is_arith ? ovf_w  : 1'b0;
                    zero_d   = (result_d == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            op_q      <= OP_AND;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            res_sh_q  <= '0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            res_sh_q  <= res_sh_d;
            carry_q   <= carry_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.result     = result_q;
    assign bus.carry_out  = cout_q;
    assign bus.overflow   = ovf_q;
    assign bus.zero       = zero_q;
    assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_bit_serial_alu.sv
// tb/tb_bit_serial_alu.sv - directed and random checks of bit_serial_alu against an arithmetic model
module tb_bit_serial_alu;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic [W-1:0] prev_res;

    bit_serial_alu_if #(.WIDTH(W)) intf ();

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output logic z, output logic ill);
        logic [W:0]   s;
        logic [W-1:0] d;
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        d = a - b;
        case (o)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            4'b0110, 4'b0111: begin
                c = (a < b);
                v = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
                r = d;
                if (o == 4'b0111) begin
`ifdef SLT_OVF_FIX_EN
                    r = ($signed(a) < $signed(b)) ? 1 : 0;
`else
                    r = {{(W-1){1'b0}}, d[W-1]};
`endif
                end
            end
            default: ill = 1'b1;
        endcase
        z = (r == '0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (intf.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", {31'b0, intf.in_ready}, 1);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] er;
        logic ec, eo, ez, ei;
        int lat;
        model(o, a, b, er, ec, eo, ez, ei);
        wait_ready();
        intf.in_valid = 1'b1;
        intf.op = o;
        intf.src_a = a;
        intf.src_b = b;
        @(negedge clk);
        intf.in_valid = 1'b0;
        intf.op = 4'($urandom);
        intf.src_a = $urandom;
        intf.src_b = $urandom;
        lat = 1;
        chk("busy_ready", intf.in_ready, 0);
        chk("illegal_on_accept", intf.illegal_op, ei);
        if (!ei) chk("result_hold", intf.result, prev_res);
        while (intf.done !== 1'b1 && lat < W + 10) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, ei ? 1 : W + 1);
        chk("result", intf.result, er);
        chk("carry_out", intf.carry_out, ec);
        chk("overflow", intf.overflow, eo);
        chk("zero", intf.zero, ez);
        chk("illegal_op", intf.illegal_op, ei);
        @(negedge clk);
        chk("done_pulse", intf.done, 0);
        chk("after_result", intf.result, er);
        prev_res = er;
    endtask

    logic [3:0] legal_ops [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [3:0] bad_ops [10] = '{4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
    logic [W-1:0] corners [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};

    function automatic logic [W-1:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        int dones, accepts;
        logic [W-1:0] er;
        logic ec, eo, ez, ei;
        rst_n = 1'b0;
        intf.in_valid = 1'b0;
        intf.op = 4'b0;
        intf.src_a = '0;
        intf.src_b = '0;
        prev_res = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", intf.in_ready, 1);
        chk("rst_done", intf.done, 0);
        chk("rst_result", intf.result, 0);
        chk("rst_flags", {intf.carry_out, intf.overflow, intf.zero, intf.illegal_op}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(4'b0110, 32'd5, 32'd7);
        run_op(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_op(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_op(4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00);
        run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
        run_op(4'b0111, 32'd5, 32'd7);
        run_op(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0);
        run_op(4'b0010, 32'd100, 32'd23);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] o;
            if ($urandom_range(0, 7) < 6) o = legal_ops[$urandom_range(0, 5)];
            else                          o = bad_ops[$urandom_range(0, 9)];
            run_op(o, pick_operand(), pick_operand());
        end

        // reset while the slice is on bit 10
        wait_ready();
        intf.in_valid = 1'b1;
        intf.op = 4'b0010;
        intf.src_a = 32'h1357_9BDF;
        intf.src_b = 32'h2468_ACE0;
        @(negedge clk);
        intf.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", intf.in_ready, 1);
        chk("midrst_done", intf.done, 0);
        chk("midrst_result", intf.result, 0);
        chk("midrst_flags", {intf.carry_out, intf.overflow, intf.zero, intf.illegal_op}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            if (intf.done === 1'b1) dones++;
        end
        chk("midrst_no_done", dones, 0);
        prev_res = '0;

        // in_valid held high: accepts only when ready, one done per accept
        model(4'b0010, 32'h1234_5678, 32'h1111_1111, er, ec, eo, ez, ei);
        intf.in_valid = 1'b1;
        intf.op = 4'b0010;
        intf.src_a = 32'h1234_5678;
        intf.src_b = 32'h1111_1111;
        dones = 0;
        accepts = 0;
        for (int i = 0; i < 3 * (W + 2); i++) begin
            if (intf.in_ready === 1'b1 && intf.done === 1'b1) chk("ready_with_done", 1, 0);
            if (intf.in_ready === 1'b1) accepts++;
            if (intf.done === 1'b1) begin
                dones++;
                chk("b2b_result", intf.result, er);
            end
            @(negedge clk);
        end
        intf.in_valid = 1'b0;
        chk("b2b_accepts", accepts, 3);
        chk("b2b_dones", dones, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
